// File: rtl/psu_match_pkg.sv
// Shared types and helpers for the PSU serial pattern matcher.
package psu_match_pkg;

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  localparam int unsigned PAT_W_MAX = 64;
  // Fill counter is sized for the widest legal window so one type serves every PAT_W.
  localparam int unsigned FILL_W = $clog2(PAT_W_MAX + 1);

  function automatic logic masked_hit(input logic [PAT_W_MAX-1:0] data,
                                      input logic [PAT_W_MAX-1:0] pattern,
                                      input logic [PAT_W_MAX-1:0] mask);
    return ((data ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/psu_stream_matcher_if.sv
// Configuration, serial stream and status signals of the PSU pattern matcher.
interface psu_stream_matcher_if #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             clr_cnt;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_mask, cfg_overlap, in_valid, in_bit, clr_cnt,
    input  match, match_cnt, cnt_sat, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_mask, cfg_overlap, in_valid, in_bit, clr_cnt,
    output match, match_cnt, cnt_sat, armed
  );
endinterface

// File: rtl/psu_sat_counter.sv
// Saturating event counter with sticky saturation flag; clear takes effect before increment.
module psu_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] nxt;

  always_comb begin
    base = clr ? '0 : count;
    nxt  = (inc && !(&base)) ? base + CNT_W'(1) : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= nxt;
      sat   <= (sat && !clr) || (&nxt);
    end
  end

endmodule

// File: rtl/psu_stream_matcher.sv
// Sliding-window serial pattern matcher with runtime pattern/mask and overlap control.
module psu_stream_matcher
  import psu_match_pkg::*;
#(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  psu_stream_matcher_if.slave bus
);

  localparam logic [FILL_W-1:0] LAST = FILL_W'(PAT_W - 1);

  // Only the newest PAT_W-1 bits are stored; the incoming bit completes the compared window.
  logic [PAT_W-2:0] win;
  logic [PAT_W-1:0] win_next;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic [FILL_W-1:0] fill;
  logic             overlap;
  logic             match_q;
  logic             armed_q;
  logic             eval;
  logic             hit;
  state_t           state;

  always_comb begin
    win_next = {win, bus.in_bit};
    eval     = bus.in_valid && !bus.cfg_load &&
               ((state == ARMED) || ((state == FILL) && (fill == LAST)));
    hit      = eval && masked_hit(PAT_W_MAX'(win_next), PAT_W_MAX'(pattern), PAT_W_MAX'(mask));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win     <= '0;
      fill    <= '0;
      pattern <= '0;
      mask    <= '0;
      overlap <= 1'b0;
      state   <= IDLE;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (bus.cfg_load) begin
        pattern <= bus.cfg_pattern;
        mask    <= bus.cfg_mask;
        overlap <= bus.cfg_overlap;
        win     <= '0;
        fill    <= '0;
        state   <= FILL;
        armed_q <= 1'b0;
      end else if (bus.in_valid && (state != IDLE)) begin
        win <= win_next[PAT_W-2:0];
        if (hit && !overlap) begin
          // Non-overlapping: a fresh PAT_W beats must arrive before the next compare.
          fill    <= '0;
          state   <= FILL;
          armed_q <= 1'b0;
        end else if (state == FILL) begin
          fill <= fill + FILL_W'(1);
          if (fill == LAST) begin
            state   <= ARMED;
            armed_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.match = match_q;
  assign bus.armed = armed_q;

  psu_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (bus.clr_cnt),
    .count (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

endmodule

// File: tb/tb_psu_stream_matcher.sv
// Self-checking bench: two matchers (CNT_W=8 and CNT_W=2) on one stimulus, checked against a queue-based model.
module tb_psu_stream_matcher;

  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          ld = 1'b0, ov = 1'b0, v = 1'b0, b = 1'b0, clr = 1'b0;
  logic [PW-1:0] pat = '0, msk = '0;

  psu_stream_matcher_if #(.PAT_W(PW), .CNT_W(8)) bus8 ();
  psu_stream_matcher_if #(.PAT_W(PW), .CNT_W(2)) bus2 ();

  assign bus8.cfg_load = ld;  assign bus2.cfg_load = ld;
  assign bus8.cfg_pattern = pat; assign bus2.cfg_pattern = pat;
  assign bus8.cfg_mask = msk; assign bus2.cfg_mask = msk;
  assign bus8.cfg_overlap = ov; assign bus2.cfg_overlap = ov;
  assign bus8.in_valid = v;   assign bus2.in_valid = v;
  assign bus8.in_bit = b;     assign bus2.in_bit = b;
  assign bus8.clr_cnt = clr;  assign bus2.clr_cnt = clr;

  psu_stream_matcher #(.PAT_W(PW), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  psu_stream_matcher #(.PAT_W(PW), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int total = 0;
  int bad = 0;
  int npulse = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits received since the last cfg_load, and beats since the last restart.
  bit            m_cfg = 0;
  int unsigned   m_since = 0;
  int unsigned   m_hits = 0;
  bit            m_match = 0;
  bit            m_hist[$];
  logic [PW-1:0] m_pat = '0, m_msk = '0;
  bit            m_ov = 0;

  function automatic void model_edge();
    bit hit;
    if (!rst_n) begin
      m_cfg = 0; m_since = 0; m_hist.delete(); m_pat = '0; m_msk = '0;
      m_ov = 0; m_hits = 0; m_match = 0;
      return;
    end
    m_match = 0;
    if (clr) m_hits = 0;
    if (ld) begin
      m_cfg = 1; m_since = 0; m_hist.delete();
      m_pat = pat; m_msk = msk; m_ov = ov;
    end else if (v && m_cfg) begin
      m_hist.push_back(b);
      if (m_hist.size() > PW) void'(m_hist.pop_front());
      if (m_since < PW) m_since++;
      if (m_since == PW) begin
        hit = 1;
        for (int i = 0; i < PW; i++)
          if (m_msk[PW-1-i] && (m_hist[i] != m_pat[PW-1-i])) hit = 0;
        if (hit) begin
          m_match = 1;
          m_hits++;
          if (!m_ov) m_since = 0;
        end
      end
    end
  endfunction

  task automatic step(input bit l, input bit vv, input bit bb, input bit c);
    bit exp_armed;
    ld = l; v = vv; b = bb; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    exp_armed = m_cfg && (m_since == PW);
    if (bus8.match === 1'b1) npulse++;
    check("match8", bus8.match, m_match);
    check("armed8", bus8.armed, exp_armed);
    check("cnt8", bus8.match_cnt, (m_hits > 255) ? 255 : m_hits);
    check("sat8", bus8.cnt_sat, m_hits >= 255);
    check("match2", bus2.match, m_match);
    check("armed2", bus2.armed, exp_armed);
    check("cnt2", bus2.match_cnt, (m_hits > 3) ? 3 : m_hits);
    check("sat2", bus2.cnt_sat, m_hits >= 3);
  endtask

  typedef struct {
    logic [PW-1:0] pat;
    logic [PW-1:0] msk;
    bit            ov;
    logic [63:0]   bits;
    int unsigned   n;
    int unsigned   exp_pulses;
    bit            exp_armed;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [63:0] w;
    tbl[0] = '{16'h157C, 16'hFFFF, 1'b1, {45'd0, 3'b101, 16'h157C}, 19, 1, 1'b1};
    tbl[1] = '{16'hAAAA, 16'hFFFF, 1'b1, 64'hAAAAA,                20, 3, 1'b1};
    tbl[2] = '{16'hAAAA, 16'hFFFF, 1'b0, 64'hAAAAAAAA,             32, 2, 1'b0};
    tbl[3] = '{16'h157C, 16'hFF00, 1'b1, 64'h15A3,                 16, 1, 1'b1};
    tbl[4] = '{16'h157C, 16'hFF00, 1'b1, 64'h14A3,                 16, 0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    check("rst_match", bus8.match, 0);
    check("rst_cnt", bus8.match_cnt, 0);
    check("rst_sat", bus8.cnt_sat, 0);
    check("rst_armed", bus8.armed, 0);
    rst_n = 1'b1;
    repeat (3) step(0, 1, 1, 0);
    check("idle_armed", bus8.armed, 0);

    // Directed vectors: load, stream MSB first, count pulses
    for (int i = 0; i < 5; i++) begin
      pat = tbl[i].pat; msk = tbl[i].msk; ov = tbl[i].ov;
      step(1, 0, 0, 1);
      npulse = 0;
      w = tbl[i].bits;
      for (int k = int'(tbl[i].n) - 1; k >= 0; k--) step(0, 1, w[k], 0);
      check("tbl_pulses", npulse, tbl[i].exp_pulses);
      check("tbl_armed", bus8.armed, tbl[i].exp_armed);
      check("tbl_cnt", bus8.match_cnt, tbl[i].exp_pulses);
    end

    // cfg_load with in_valid mid-pattern restarts the fill
    pat = 16'h157C; msk = 16'hFFFF; ov = 1'b1;
    step(1, 0, 0, 0);
    for (int k = 15; k >= 6; k--) step(0, 1, pat[k], 0);
    step(1, 1, pat[5], 0);
    npulse = 0;
    for (int j = 0; j < 16; j++) begin
      step(0, 1, (j < 5) ? pat[4-j] : 1'b0, 0);
      if (j < 15) check("reload_armed_low", bus8.armed, 0);
    end
    check("reload_pulses", npulse, 0);
    check("reload_armed", bus8.armed, 1);

    // Saturation with mask=0 on the CNT_W=2 instance, then clear on a hit beat
    msk = '0; ov = 1'b1;
    step(1, 0, 0, 1);
    repeat (15) step(0, 1, 1'($urandom_range(0, 1)), 0);
    for (int j = 0; j < 4; j++) begin
      step(0, 1, 1'($urandom_range(0, 1)), 0);
      check("sat_cnt2", bus2.match_cnt, (j < 2) ? j + 1 : 3);
      check("sat_flag2", bus2.cnt_sat, j >= 2);
    end
    step(0, 1, 0, 1);
    check("clrhit_cnt2", bus2.match_cnt, 1);
    check("clrhit_sat2", bus2.cnt_sat, 0);
    check("clrhit_match", bus2.match, 1);
    repeat (260) step(0, 1, 1'($urandom_range(0, 1)), 0);
    check("sat_cnt8", bus8.match_cnt, 255);
    check("sat_flag8", bus8.cnt_sat, 1);

    // Reset while armed discards everything; stream ignored until cfg_load
    rst_n = 1'b0;
    step(0, 1, 1, 0);
    check("armrst_match", bus8.match, 0);
    check("armrst_cnt", bus8.match_cnt, 0);
    check("armrst_sat", bus8.cnt_sat, 0);
    check("armrst_armed", bus8.armed, 0);
    rst_n = 1'b1;
    npulse = 0;
    repeat (20) step(0, 1, 1'($urandom_range(0, 1)), 0);
    check("armrst_pulses", npulse, 0);

    // Randomized traffic against the model
    for (int r = 0; r < 40; r++) begin
      pat = PW'($urandom);
      case ($urandom_range(0, 3))
        0:       msk = '0;
        1:       msk = '1;
        default: msk = PW'($urandom) & PW'($urandom) & PW'($urandom);
      endcase
      ov = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        step(0, 1, 1, 0);
        rst_n = 1'b1;
      end
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(20, 150))
        step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
